mix_columns_seq: RTL
====================

// Module: mix_columns_seq
// PURPOSE
//  AES MixColumns stage that sits directly downstream of ShiftRows and consumes its 16-byte state.
//  Transforms COLS_PER_CYCLE columns per clock over GF(2^8), so area can be traded against latency.
//  Uses a valid/ready handshake on both sides; a bypass input skips the transform for the final round.
//  Byte index = 4*col + row, so row 0 holds bytes 0, 4, 8 and 12 (same ordering as the ShiftRows output).
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error
// PORTS
//  clk        in   1         single clock; all logic on posedge
//  rst_n      in   1         synchronous, active-low reset
//  text_sr    in   8 x [16]  input state from ShiftRows (input [7:0] text_sr [15:0])
//  enbmc      in   1         1 = apply MixColumns, 0 = pass through; sampled only on input accept
//  in_valid   in   1         text_sr/enbmc valid
//  in_ready   out  1         block can accept a state
//  text_mc    out  8 x [16]  output state (output [7:0] text_mc [15:0])
//  out_valid  out  1         text_mc valid
//  out_ready  in   1         consumer accepts text_mc
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, col counter=0, internal state regs and text_mc all 8'h00,
//   out_valid=0, in_ready=1. A reset mid-operation aborts the block; the partial result is discarded.
//  Outputs are registered or decoded from state only; there is no combinational in->out path.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: in_ready=1, out_valid=0. On accept (in_valid & in_ready):
//   - latch all 16 bytes and enbmc;
//   - if enbmc=1: go to BUSY with col=0;
//   - if enbmc=0: go straight to DONE with the data unchanged.
//  BUSY: in_ready=0.
//   - Each edge updates columns col .. col+C-1 in place, then col += C (C = COLS_PER_CYCLE).
//   - After N = 4/C BUSY edges, go to DONE; col wraps to 0.
//  DONE: out_valid=1, in_ready=0, text_mc equals the final state.
//   - text_mc is held stable while out_ready=0, for any number of cycles.
//   - On out_ready=1, go to IDLE; out_valid drops at the next edge.
//  Latency (accept cycle -> first out_valid cycle): bypass = 1; transform = 1+N (C=1: 5, C=2: 3, C=4: 2).
//  Throughput: one state per 2+N cycles. No accept in the same cycle as the DONE handshake (1 bubble).
//  in_valid while not IDLE is ignored; upstream must hold its data until in_ready.
//  Column math, with a0..a3 = rows 0..3 of one column:
//   - r0 = 2a0^3a1^a2^a3;  r1 = a0^2a1^3a2^a3
//   - r2 = a0^a1^2a2^3a3;  r3 = 3a0^a1^a2^2a3
//   - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); 3b = xtime(b)^b
//   - all results are 8-bit; no carries beyond bit 7.
//  Columns not yet processed hold their input values; text_mc updates only on entering DONE.
// TESTING
//  1. Col0 = db 13 53 45, enbmc=1, out_ready=1 -> col0 out = 8e 4d a1 bc.
//     Check latency 5/3/2 for C=1/2/4.
//  2. Cols = f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6 | d4 d4 d4 d5
//     -> 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6 | d5 d5 d7 d6.
//  3. enbmc=0 with any state -> text_mc == text_sr; out_valid the cycle after accept.
//  4. out_ready held 0 for 10 cycles in DONE -> out_valid stays 1, text_mc stable, in_ready=0.
//     Release -> IDLE, then a new accept.
//  5. rst_n=0 for one edge during BUSY (col=2, C=1) -> IDLE, out_valid=0, text_mc=0.
//     The next state (col 2d 26 31 4c) -> 4d 7e bd f8.
//  6. in_valid toggled during BUSY/DONE -> nothing accepted; back-to-back states show 1 bubble cycle.

Source files
------------

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES MixColumns, COLS_PER_CYCLE columns per clock
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   text_sr    16-byte input state from ShiftRows (byte index = 4*col + row)
//   enbmc      1 = apply MixColumns, 0 = pass through (sampled on accept)
//   in_valid   text_sr/enbmc valid
//   in_ready   block can accept a state (IDLE)
//   text_mc    16-byte output state, updated only on entering DONE
//   out_valid  text_mc valid (DONE)
//   out_ready  consumer accepts text_mc
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] text_sr [15:0],
    input  logic       enbmc,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] text_mc [15:0],
    output logic       out_valid,
    input  logic       out_ready
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Column index of the last BUSY step; the step width wraps to 0 when C = 4.
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] col_q;
    logic [7:0] data_q    [15:0];
    logic [7:0] data_d    [15:0];
    logic [7:0] text_mc_q [15:0];
    logic       out_valid_q;
    logic       in_ready_q;

    logic [3:0]  base;
    logic [31:0] col_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // Returns {r3, r2, r1, r0} for one column a0..a3 (rows 0..3).
    function automatic logic [31:0] mix_column(input logic [7:0] a0, input logic [7:0] a1,
                                               input logic [7:0] a2, input logic [7:0] a3);
        logic [7:0] r0, r1, r2, r3;
        r0 = xtime(a0) ^ mul3(a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ mul3(a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ mul3(a3);
        r3 = mul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r3, r2, r1, r0};
    endfunction

    // Transform columns col_q .. col_q+C-1 in place; the rest keep their values.
    always_comb begin
        data_d  = data_q;
        base    = '0;
        col_res = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            base    = {col_q + 2'(k), 2'b00};
            col_res = mix_column(data_q[base], data_q[base + 4'd1],
                                 data_q[base + 4'd2], data_q[base + 4'd3]);
            data_d[base]        = col_res[7:0];
            data_d[base + 4'd1] = col_res[15:8];
            data_d[base + 4'd2] = col_res[23:16];
            data_d[base + 4'd3] = col_res[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                data_q[i]    <= 8'h00;
                text_mc_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            data_q[i] <= text_sr[i];
                        end
                        in_ready_q <= 1'b0;
                        if (enbmc) begin
                            state_q <= BUSY;
                            col_q   <= '0;
                        end else begin
                            // Bypass: the untouched input is the final state.
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            for (int i = 0; i < 16; i++) begin
                                text_mc_q[i] <= text_sr[i];
                            end
                        end
                    end
                end
                BUSY: begin
                    data_q <= data_d;
                    if (col_q == LAST_COL) begin
                        state_q     <= DONE;
                        col_q       <= '0;
                        out_valid_q <= 1'b1;
                        text_mc_q   <= data_d;
                    end else begin
                        col_q <= col_q + COL_STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    col_q       <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign text_mc   = text_mc_q;

endmodule
